// File: rtl/atrover_pkg.sv
// Shared types and default sizing for the program/data RAM port arbiter.
package atrover_pkg;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_LDR = 1'b1
    } owner_e;

    localparam int WL_DEFAULT        = 32;
    localparam int NB_COL_DEFAULT    = 4;
    localparam int RAM_DEPTH_DEFAULT = 8192;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a loader lock; grant[0] = CPU, grant[1] = LDR.
module rr_arb2
    import atrover_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    input  logic       cpu_valid,
    input  logic       ldr_valid,
    output logic [1:0] grant
);

    owner_e rr_last;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant = 2'b00;
        if (!reset) begin
            if (lock) begin
                grant[1] = ldr_valid;
            end else if (cpu_valid && ldr_valid) begin
                if (rr_last == OWNER_LDR) grant[0] = 1'b1;
                else                      grant[1] = 1'b1;
            end else begin
                grant[0] = cpu_valid;
                grant[1] = ldr_valid;
            end
        end
    end

    // Ready equals grant, so any grant is an accepted command.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset)         rr_last <= OWNER_LDR;
        else if (grant[0]) rr_last <= OWNER_CPU;
        else if (grant[1]) rr_last <= OWNER_LDR;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the RAM data port between the CPU dBus and the UART loader, one command
// per cycle, with a one-deep read response pipeline routed back to the owner.
module ram_port_arbiter
    import atrover_pkg::*;
#(
    parameter  int WL          = WL_DEFAULT,
    parameter  int NB_COL      = NB_COL_DEFAULT,
    parameter  int RAM_DEPTH   = RAM_DEPTH_DEFAULT,
    localparam int RAM_ADDR_WL = $clog2(RAM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ldr_lock,

    input  logic                   cpu_cmd_valid,
    output logic                   cpu_cmd_ready,
    input  logic                   cpu_cmd_wr,
    input  logic [WL-1:0]          cpu_cmd_addr,
    input  logic [NB_COL-1:0]      cpu_cmd_be,
    input  logic [WL-1:0]          cpu_cmd_wdata,
    output logic                   cpu_rsp_valid,
    output logic                   cpu_rsp_error,
    output logic [WL-1:0]          cpu_rsp_rdata,

    input  logic                   ldr_cmd_valid,
    output logic                   ldr_cmd_ready,
    input  logic                   ldr_cmd_wr,
    input  logic [WL-1:0]          ldr_cmd_addr,
    input  logic [NB_COL-1:0]      ldr_cmd_be,
    input  logic [WL-1:0]          ldr_cmd_wdata,
    output logic                   ldr_rsp_valid,
    output logic                   ldr_rsp_error,
    output logic [WL-1:0]          ldr_rsp_rdata,

    output logic [NB_COL-1:0]      ram_we,
    output logic [RAM_ADDR_WL-1:0] ram_addr,
    output logic [WL-1:0]          ram_din,
    input  logic [WL-1:0]          ram_dout
);

    logic [1:0]        grant;
    logic              sel_ldr;
    logic              granted;
    logic              sel_wr;
    logic [WL-1:0]     sel_addr;
    logic [NB_COL-1:0] sel_be;
    logic [WL-1:0]     sel_wdata;
    logic              oor;
    logic [1:0]        unused_addr_lsb;

    logic              rsp_valid_q;
    owner_e            rsp_owner_q;
    logic              rsp_oor_q;
    logic              rsp_live;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .lock      (ldr_lock),
        .cpu_valid (cpu_cmd_valid),
        .ldr_valid (ldr_cmd_valid),
        .grant     (grant)
    );

    assign cpu_cmd_ready = grant[0];
    assign ldr_cmd_ready = grant[1];
    assign sel_ldr       = grant[1];
    assign granted       = |grant;

    // With no grant the CPU side drives the RAM address/data lines.
    assign sel_wr    = sel_ldr ? ldr_cmd_wr    : cpu_cmd_wr;
    assign sel_addr  = sel_ldr ? ldr_cmd_addr  : cpu_cmd_addr;
    assign sel_be    = sel_ldr ? ldr_cmd_be    : cpu_cmd_be;
    assign sel_wdata = sel_ldr ? ldr_cmd_wdata : cpu_cmd_wdata;

    assign oor             = |sel_addr[WL-1:RAM_ADDR_WL+2];
    assign unused_addr_lsb = sel_addr[1:0];

    assign ram_addr = sel_addr[RAM_ADDR_WL+1:2];
    assign ram_din  = sel_wdata;
    assign ram_we   = (granted && sel_wr && !oor) ? sel_be : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= OWNER_CPU;
            rsp_oor_q   <= 1'b0;
        end else begin
            rsp_valid_q <= granted && !sel_wr;
            rsp_owner_q <= sel_ldr ? OWNER_LDR : OWNER_CPU;
            rsp_oor_q   <= oor;
        end
    end

    // Reset also masks a response already in flight, so it is never presented.
    assign rsp_live = rsp_valid_q && !reset;

    assign cpu_rsp_valid = rsp_live && (rsp_owner_q == OWNER_CPU);
    assign ldr_rsp_valid = rsp_live && (rsp_owner_q == OWNER_LDR);
    assign cpu_rsp_error = cpu_rsp_valid && rsp_oor_q;
    assign ldr_rsp_error = ldr_rsp_valid && rsp_oor_q;
    assign cpu_rsp_rdata = (cpu_rsp_valid && !rsp_oor_q) ? ram_dout : '0;
    assign ldr_rsp_rdata = (ldr_rsp_valid && !rsp_oor_q) ? ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table plus hand sequences, a behavioural RAM
// and a scoreboard of expected read responses.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset, ldr_lock;
    logic        cpu_cmd_valid, cpu_cmd_ready, cpu_cmd_wr;
    logic [31:0] cpu_cmd_addr, cpu_cmd_wdata, cpu_rsp_rdata;
    logic [3:0]  cpu_cmd_be;
    logic        cpu_rsp_valid, cpu_rsp_error;
    logic        ldr_cmd_valid, ldr_cmd_ready, ldr_cmd_wr;
    logic [31:0] ldr_cmd_addr, ldr_cmd_wdata, ldr_rsp_rdata;
    logic [3:0]  ldr_cmd_be;
    logic        ldr_rsp_valid, ldr_rsp_error;
    logic [3:0]  ram_we;
    logic [12:0] ram_addr;
    logic [31:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset), .ldr_lock(ldr_lock),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready), .cpu_cmd_wr(cpu_cmd_wr),
        .cpu_cmd_addr(cpu_cmd_addr), .cpu_cmd_be(cpu_cmd_be), .cpu_cmd_wdata(cpu_cmd_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_error(cpu_rsp_error), .cpu_rsp_rdata(cpu_rsp_rdata),
        .ldr_cmd_valid(ldr_cmd_valid), .ldr_cmd_ready(ldr_cmd_ready), .ldr_cmd_wr(ldr_cmd_wr),
        .ldr_cmd_addr(ldr_cmd_addr), .ldr_cmd_be(ldr_cmd_be), .ldr_cmd_wdata(ldr_cmd_wdata),
        .ldr_rsp_valid(ldr_rsp_valid), .ldr_rsp_error(ldr_rsp_error), .ldr_rsp_rdata(ldr_rsp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural RAM: read-before-write, one cycle read latency.
    logic [31:0] mem [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = {16'hC0DE, 16'(i)};
        mem[4] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            ram_dout = mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b] === 1'b1) mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
        end
    end

    typedef struct {
        bit          rst, lock;
        bit          cv, cwr;
        logic [31:0] ca, cwd;
        logic [3:0]  cbe;
        bit          lv, lwr;
        logic [31:0] la, lwd;
        logic [3:0]  lbe;
        bit          ecr, elr;
        logic [3:0]  ewe;
    } vec_t;

    typedef struct {
        bit          is_ldr;
        logic        err;
        logic [31:0] rdata;
        int          stamp;
    } rsp_t;

    logic [31:0] ref_mem [0:8191];
    rsp_t        sb[$];
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          step_no = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    function automatic vec_t mk(bit rst, bit lock, bit cv, bit cwr, logic [31:0] ca,
                                logic [3:0] cbe, logic [31:0] cwd, bit lv, bit lwr,
                                logic [31:0] la, logic [3:0] lbe, logic [31:0] lwd,
                                bit ecr, bit elr, logic [3:0] ewe);
        vec_t v;
        v.rst = rst; v.lock = lock;
        v.cv = cv; v.cwr = cwr; v.ca = ca; v.cbe = cbe; v.cwd = cwd;
        v.lv = lv; v.lwr = lwr; v.la = la; v.lbe = lbe; v.lwd = lwd;
        v.ecr = ecr; v.elr = elr; v.ewe = ewe;
        return v;
    endfunction

    // Read-only shorthand.
    function automatic vec_t rd(bit rst, bit lock, bit cv, logic [31:0] ca, bit lv,
                                logic [31:0] la, bit ecr, bit elr);
        return mk(rst, lock, cv, 1'b0, ca, 4'h0, 32'h0, lv, 1'b0, la, 4'h0, 32'h0, ecr, elr, 4'h0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, step_no, act, exp);
        end
    endtask

    task automatic check_rsp();
        rsp_t e;
        bit   cv, lv;
        cv = (cpu_rsp_valid === 1'b1);
        lv = (ldr_rsp_valid === 1'b1);
        check("single_rsp", 32'(cv && lv), 32'h0);
        if (cv || lv) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp (step %0d): got cpu=%0b ldr=%0b, expected none",
                         step_no, cv, lv);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", 32'(lv), 32'(e.is_ldr));
                check("rsp_latency", step_no, e.stamp + 1);
                last_err   = lv ? ldr_rsp_error : cpu_rsp_error;
                last_rdata = lv ? ldr_rsp_rdata : cpu_rsp_rdata;
                check("rsp_error", 32'(last_err), 32'(e.err));
                check("rsp_rdata", last_rdata, e.rdata);
            end
        end else if (sb.size() > 0 && sb[0].stamp + 1 <= step_no) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_rsp (step %0d): got none, expected rsp from step %0d",
                     step_no, e.stamp);
        end
    endtask

    task automatic step(input vec_t v, input bit push_en);
        bit          is_ldr;
        bit          wr, oor;
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic [12:0] word;
        rsp_t        e;
        reset = v.rst; ldr_lock = v.lock;
        cpu_cmd_valid = v.cv; cpu_cmd_wr = v.cwr; cpu_cmd_addr = v.ca;
        cpu_cmd_be = v.cbe; cpu_cmd_wdata = v.cwd;
        ldr_cmd_valid = v.lv; ldr_cmd_wr = v.lwr; ldr_cmd_addr = v.la;
        ldr_cmd_be = v.lbe; ldr_cmd_wdata = v.lwd;
        #1;
        check_rsp();
        if (v.rst)
            check("rsp_in_reset", {cpu_rsp_valid, ldr_rsp_valid, cpu_rsp_error, ldr_rsp_error}
                  | cpu_rsp_rdata | ldr_rsp_rdata, 32'h0);
        check("cpu_ready", 32'(cpu_cmd_ready), 32'(v.ecr));
        check("ldr_ready", 32'(ldr_cmd_ready), 32'(v.elr));
        check("ram_we", 32'(ram_we), 32'(v.ewe));
        if (v.ecr || v.elr) begin
            is_ldr = v.elr;
            a      = is_ldr ? v.la  : v.ca;
            wr     = is_ldr ? v.lwr : v.cwr;
            be     = is_ldr ? v.lbe : v.cbe;
            wd     = is_ldr ? v.lwd : v.cwd;
            oor    = |a[31:15];
            word   = a[14:2];
            check("ram_addr", 32'(ram_addr), 32'(word));
            if (wr) begin
                if (!oor)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
            end else if (push_en) begin
                e.is_ldr = is_ldr;
                e.err    = oor;
                e.rdata  = oor ? 32'h0 : ref_mem[word];
                e.stamp  = step_no;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        step_no++;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ref_mem[i] = {16'hC0DE, 16'(i)};
        ref_mem[4] = 32'hDEADBEEF;

        // Reset with traffic present, then a first CPU read.
        tbl.push_back(mk(1, 0, 1, 1, 32'h0, 4'hF, 32'h1234_5678, 1, 0, 32'h8, 4'h0, 32'h0, 0, 0, 4'h0));
        tbl.push_back(rd(1, 0, 0, 32'h0,  0, 32'h0, 0, 0));
        tbl.push_back(rd(0, 0, 1, 32'h10, 0, 32'h0, 1, 0));
        tbl.push_back(rd(0, 0, 0, 32'h0,  0, 32'h0, 0, 0));
        tbl.push_back(rd(1, 0, 0, 32'h0,  0, 32'h0, 0, 0));
        // Six-cycle tie: CPU first, then alternate.
        for (int i = 0; i < 6; i++)
            tbl.push_back(rd(0, 0, 1, 32'h20, 1, 32'h40, (i % 2) == 0, (i % 2) == 1));
        // Locked: loader only.
        for (int i = 0; i < 4; i++)
            tbl.push_back(rd(0, 1, 1, 32'h24, 1, 32'h44, 0, 1));
        tbl.push_back(rd(0, 0, 1, 32'h28, 1, 32'h48, 1, 0));
        tbl.push_back(rd(0, 0, 1, 32'h28, 1, 32'h48, 0, 1));
        tbl.push_back(rd(0, 0, 0, 32'h0,  0, 32'h0,  0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

        // Byte-lane write then read-back.
        step(mk(0, 0, 1, 1, 32'h6, 4'b0100, 32'h00AB_0000, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 4'b0100), 1'b1);
        step(rd(0, 0, 1, 32'h4, 0, 32'h0, 1, 0), 1'b1);
        step(rd(0, 0, 0, 32'h0, 0, 32'h0, 0, 0), 1'b1);
        check("wr_readback_byte2", 32'(last_rdata[23:16]), 32'hAB);

        // Out-of-range loader read and write.
        step(rd(0, 0, 0, 32'h0, 1, 32'h0001_0000, 0, 1), 1'b1);
        step(rd(0, 0, 0, 32'h0, 0, 32'h0, 0, 0), 1'b1);
        check("oor_error", 32'(last_err), 32'h1);
        check("oor_rdata", last_rdata, 32'h0);
        step(mk(0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 0, 1, 4'h0), 1'b1);
        step(rd(0, 0, 1, 32'h0, 0, 32'h0, 1, 0), 1'b1);
        step(rd(0, 0, 0, 32'h0, 0, 32'h0, 0, 0), 1'b1);
        check("oor_write_no_effect", last_rdata, 32'hC0DE_0000);

        // Reset right after an accepted read: response dropped, CPU wins next tie.
        step(rd(0, 0, 1, 32'h10, 0, 32'h0, 1, 0), 1'b0);
        step(rd(1, 0, 1, 32'h10, 1, 32'h14, 0, 0), 1'b1);
        step(rd(0, 0, 1, 32'h30, 1, 32'h50, 1, 0), 1'b1);
        step(rd(0, 0, 0, 32'h0,  0, 32'h0,  0, 0), 1'b1);

        check("scoreboard_empty", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
